sort_result_serializer: RTL and testbench

Drain-side companion to the bitonic sort/merge network. It captures each SIZE-wide sorted vector emitted by the fixed-latency, non-stallable network into a small slot buffer. It then streams the vector out one element per transfer over a valid/ready interface, flagging the last element. This absorbs downstream backpressure the network itself cannot honour, and reports any vector dropped for lack of space.

---
 rtl/sort_result_serializer_if.sv | 26 ++
 rtl/sort_result_serializer.sv | 84 ++++++++
 tb/tb_sort_result_serializer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sort_result_serializer_if.sv
// Vector-in / element-out bus of the sort result serializer.
// slave faces the serializer, master faces the network and downstream consumer.
interface sort_result_serializer_if #(
  parameter int VALUE_BITS = 8,
  parameter int DEPTH      = 4
);
  localparam int SIZE = 1 << DEPTH;

  logic                                vec_valid;
  logic [SIZE-1:0][VALUE_BITS-1:0]     vec_in;
  logic                                out_valid;
  logic                                out_ready;
  logic [VALUE_BITS-1:0]               out_data;
  logic [DEPTH-1:0]                    out_index;
  logic                                out_last;

  modport slave (
    input  vec_valid, vec_in, out_ready,
    output out_valid, out_data, out_index, out_last
  );

  modport master (
    output vec_valid, vec_in, out_ready,
    input  out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/sort_result_serializer.sv
// Buffers whole sorted vectors from a non-stallable network and streams them out one element per transfer.
// Element 0 is visible the cycle after capture; out_ready stalls hold output stable; no slot free drops and flags overflow.
module sort_result_serializer #(
  parameter int VALUE_BITS = 8,
  parameter int DEPTH      = 4,
  parameter int SLOTS      = 2,
  localparam int SIZE      = 1 << DEPTH,
  localparam int PTR_W     = $clog2(SLOTS),
  localparam int OCC_W     = $clog2(SLOTS) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sort_result_serializer_if.slave   bus,
  input  logic                      clear_overflow,
  output logic [OCC_W-1:0]          occupancy,
  output logic                      overflow
);

  logic [SIZE-1:0][VALUE_BITS-1:0] slot_mem [SLOTS];
  logic [PTR_W-1:0]                wr_ptr;
  logic [PTR_W-1:0]                rd_ptr;
  logic [DEPTH-1:0]                elem_idx;

  logic at_last;
  logic xfer;
  logic last_xfer;
  logic slot_avail;
  logic capture;
  logic drop;

  assign at_last       = (elem_idx == DEPTH'(SIZE - 1));
  assign bus.out_valid = (occupancy != '0);
  assign bus.out_data  = slot_mem[rd_ptr][elem_idx];
  assign bus.out_index = elem_idx;
  assign bus.out_last  = bus.out_valid && at_last;

  assign xfer      = bus.out_valid && bus.out_ready;
  assign last_xfer = xfer && at_last;
  // A full buffer still accepts when its oldest slot drains on this very edge.
  assign slot_avail = (occupancy < OCC_W'(SLOTS)) || last_xfer;
  assign capture    = bus.vec_valid && slot_avail;
  assign drop       = bus.vec_valid && !slot_avail;

  always_ff @(posedge clk) begin
    if (capture) begin
      slot_mem[wr_ptr] <= bus.vec_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      elem_idx  <= '0;
      occupancy <= '0;
      overflow  <= 1'b0;
    end else begin
      if (capture) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (last_xfer) begin
        rd_ptr   <= rd_ptr + 1'b1;
        elem_idx <= '0;
      end else if (xfer) begin
        elem_idx <= elem_idx + 1'b1;
      end

      case ({capture, last_xfer})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase

      // A drop coinciding with a clear leaves the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sort_result_serializer.sv
// Directed bench for sort_result_serializer: in-order draining, stalls, overflow, same-cycle refill, async reset.
module tb_sort_result_serializer;
  localparam int VB = 8;
  localparam int DP = 4;
  localparam int SZ = 16;
  localparam int SL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [1:0] occupancy;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sort_result_serializer_if #(.VALUE_BITS(VB), .DEPTH(DP)) bus ();

  sort_result_serializer #(.VALUE_BITS(VB), .DEPTH(DP), .SLOTS(SL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .clear_overflow (clear_overflow),
    .occupancy      (occupancy),
    .overflow       (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.vec_valid = 1'b0;
    bus.vec_in    = '0;
    bus.out_ready = 1'b0;
    clear_overflow = 1'b0;
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Present vector base+i; keep=1 means the bench expects it to be captured.
  task automatic load(input logic [7:0] base, input bit keep);
    for (int i = 0; i < SZ; i++) begin
      bus.vec_in[i] = base + 8'(i);
      if (keep) exp_q.push_back(base + 8'(i));
    end
    bus.vec_valid = 1'b1;
  endtask

  // Receive n elements; stall_mode drives ready 1,0,0,...; inject presents a new vector alongside the n-th transfer.
  task automatic recv(input int n, input bit stall_mode, input bit inject, input logic [7:0] inj_base);
    int         cnt;
    int         c;
    logic       held_vld;
    logic [7:0] held_dat;
    logic [3:0] held_idx;
    logic       held_last;
    logic [7:0] e;
    cnt = 0;
    c = 0;
    held_vld = 1'b0;
    held_dat = '0;
    held_idx = '0;
    held_last = 1'b0;
    while (cnt < n && c < 4000) begin
      bus.out_ready = stall_mode ? (c % 3 == 0) : 1'b1;
      if (held_vld) begin
        chk("stall_data", 32'(bus.out_data), 32'(held_dat));
        chk("stall_index", 32'(bus.out_index), 32'(held_idx));
        chk("stall_last", 32'(bus.out_last), 32'(held_last));
      end
      if (!stall_mode) chk("no_bubble", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("data", 32'(bus.out_data), 32'(e));
        end else begin
          chk("unexpected_elem", 32'(bus.out_data), 32'hDEAD_BEEF);
        end
        chk("index", 32'(bus.out_index), 32'(cnt % SZ));
        chk("last", 32'(bus.out_last), 32'((cnt % SZ) == SZ - 1));
        if (inject && cnt == n - 1) load(inj_base, 1'b1);
        cnt++;
      end
      held_vld  = bus.out_valid && !bus.out_ready;
      held_dat  = bus.out_data;
      held_idx  = bus.out_index;
      held_last = bus.out_last;
      step();
      bus.vec_valid = 1'b0;
      c++;
    end
    chk("recv_count", 32'(cnt), 32'(n));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_index", 32'(bus.out_index), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);

    // Single vector, ready held high
    load(8'd3, 1'b1);
    step();
    bus.vec_valid = 1'b0;
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_data", 32'(bus.out_data), 32'd3);
    chk("lat_occ", 32'(occupancy), 32'd1);
    recv(SZ, 1'b0, 1'b0, 8'd0);
    chk("t1_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_occ", 32'(occupancy), 32'd0);
    bus.out_ready = 1'b1;
    step();
    chk("idle_ready_index", 32'(bus.out_index), 32'd0);
    chk("idle_ready_occ", 32'(occupancy), 32'd0);
    bus.out_ready = 1'b0;

    // Same vector with ready toggling
    do_reset();
    load(8'd3, 1'b1);
    step();
    bus.vec_valid = 1'b0;
    recv(SZ, 1'b1, 1'b0, 8'd0);
    chk("t2_valid", 32'(bus.out_valid), 32'd0);

    // A, B captured, C dropped while stalled
    do_reset();
    load(8'h10, 1'b1);
    step();
    load(8'h40, 1'b1);
    step();
    load(8'h80, 1'b0);
    step();
    bus.vec_valid = 1'b0;
    chk("t3_occ", 32'(occupancy), 32'd2);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_head", 32'(bus.out_data), 32'h10);

    // Clear overflow, then clear colliding with a drop
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    step();
    chk("clr_hold", 32'(overflow), 32'd0);
    load(8'h80, 1'b0);
    clear_overflow = 1'b1;
    step();
    bus.vec_valid = 1'b0;
    clear_overflow = 1'b0;
    chk("clr_vs_drop_ovf", 32'(overflow), 32'd1);
    chk("clr_vs_drop_occ", 32'(occupancy), 32'd2);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    chk("clr2_ovf", 32'(overflow), 32'd0);

    // Full buffer refilled on A's last transfer; then B and D drain back-to-back
    recv(SZ, 1'b0, 1'b1, 8'hD0);
    chk("refill_occ", 32'(occupancy), 32'd2);
    chk("refill_ovf", 32'(overflow), 32'd0);
    recv(2 * SZ, 1'b0, 1'b0, 8'd0);
    chk("t4_occ", 32'(occupancy), 32'd0);
    chk("t4_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_ovf", 32'(overflow), 32'd0);

    // Asynchronous reset mid-vector
    do_reset();
    load(8'hC0, 1'b1);
    step();
    bus.vec_valid = 1'b0;
    recv(5, 1'b0, 1'b0, 8'd0);
    chk("mid_index", 32'(bus.out_index), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_index", 32'(bus.out_index), 32'd0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    load(8'hE0, 1'b1);
    step();
    bus.vec_valid = 1'b0;
    chk("fresh_index", 32'(bus.out_index), 32'd0);
    chk("fresh_data", 32'(bus.out_data), 32'hE0);
    recv(SZ, 1'b0, 1'b0, 8'd0);
    chk("t6_occ", 32'(occupancy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
